// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped console: register offsets, STATUS bit
// positions and the register-select enum decoded from DataAdr[3:2].
package mmio_pkg;

    typedef enum logic [1:0] {
        REG_TXDATA  = 2'd0,
        REG_STATUS  = 2'd1,
        REG_CYCLE   = 2'd2,
        REG_TXCOUNT = 2'd3
    } reg_sel_e;

    // Byte offsets of each register within the 16-byte window.
    localparam logic [3:0] OFS_TXDATA  = 4'h0;
    localparam logic [3:0] OFS_STATUS  = 4'h4;
    localparam logic [3:0] OFS_CYCLE   = 4'h8;
    localparam logic [3:0] OFS_TXCOUNT = 4'hC;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_COUNT_LSB = 4;
    localparam int STATUS_COUNT_W   = 5;

endpackage

// File: rtl/mmio_console_txfifo.sv
// Transmit FIFO for the console: power-of-two depth, registered storage,
// head exposed directly on rdata (zero when empty), no push-to-head bypass.
module txfifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_MAX);
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    // A pop frees the slot on the same edge, so a push at full is still accepted.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mmio_console.sv
// Memory-mapped console sitting between the core and dmem: decodes a 16-byte
// window, feeds a TX FIFO and keeps counters. Optional CYCLE counter: MMIO_CYCLE_COUNTER_EN.
module mmio_console
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic [31:0] MemReadData,
    output logic [31:0] ReadData,
    output logic        DmemWE,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             hit;
    reg_sel_e         sel;
    logic             reg_we;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      status_word, cycle_val, reg_rdata;
    logic             overflow_q, overflow_d;
    logic [31:0]      txcount_q, txcount_d;
    logic             unused_bits;

    assign hit         = (DataAdr[31:4] == BASE_ADDR[31:4]);
    assign sel         = reg_sel_e'(DataAdr[3:2]);
    assign reg_we      = MemWrite & hit;
    assign DmemWE      = MemWrite & ~hit;
    assign fifo_push   = reg_we & (sel == REG_TXDATA);
    assign fifo_pop    = tx_valid & tx_ready;
    assign tx_valid    = ~fifo_empty;
    assign unused_bits = ^{DataAdr[1:0], WriteData};

    txfifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_txfifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (WriteData[7:0]),
        .pop   (fifo_pop),
        .rdata (tx_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [31:0] cycle_q, cycle_d;

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (reg_we && sel == REG_CYCLE) cycle_d = WriteData;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cycle_q <= '0;
        else        cycle_q <= cycle_d;
    end

    assign cycle_val = cycle_q;
`else
    assign cycle_val = '0;
`endif

    // Set after clear: an overflowing push wins over a same-cycle STATUS write.
    always_comb begin
        overflow_d = overflow_q;
        if (reg_we && sel == REG_STATUS) overflow_d = 1'b0;
        if (fifo_drop) overflow_d = 1'b1;
        txcount_d = fifo_pop ? txcount_q + 32'd1 : txcount_q;
        if (reg_we && sel == REG_TXCOUNT) txcount_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
            txcount_q  <= '0;
        end else begin
            overflow_q <= overflow_d;
            txcount_q  <= txcount_d;
        end
    end

    always_comb begin
        status_word = '0;
        status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
        status_word[STATUS_OVF_BIT]   = overflow_q;
        status_word[STATUS_EMPTY_BIT] = fifo_empty;
        status_word[STATUS_FULL_BIT]  = fifo_full;
        case (sel)
            REG_TXDATA:  reg_rdata = '0;
            REG_STATUS:  reg_rdata = status_word;
            REG_CYCLE:   reg_rdata = cycle_val;
            REG_TXCOUNT: reg_rdata = txcount_q;
            default:     reg_rdata = '0;
        endcase
        ReadData = hit ? reg_rdata : MemReadData;
    end

endmodule

// File: tb/tb_mmio_console.sv
// Directed self-checking bench for mmio_console; expected CYCLE values follow
// MMIO_CYCLE_COUNTER_EN when the bench is built with the same define.
module tb_mmio_console;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] MemReadData = 32'h1234_5678;
    logic        tx_ready = 1'b0;
    logic [31:0] ReadData;
    logic        DmemWE;
    logic        tx_valid;
    logic [7:0]  tx_data;

    int errors = 0;
    int checks = 0;

    mmio_console #(
        .BASE_ADDR  (32'h0000_0400),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .DataAdr     (DataAdr),
        .WriteData   (WriteData),
        .MemReadData (MemReadData),
        .ReadData    (ReadData),
        .DmemWE      (DmemWE),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; returns at the next falling edge after one write edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        MemWrite  = 1'b1;
        DataAdr   = addr;
        WriteData = data;
        @(negedge clk);
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
    endtask

    task automatic set_addr(input logic [31:0] addr);
        DataAdr = addr;
        #1;
    endtask

    task automatic test_reset;
        set_addr(32'h404);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", tx_data); end
        checks++; if (ReadData !== 32'h002) begin errors++; $display("FAIL reset_status: got %h want 00000002", ReadData); end
        set_addr(32'h40C);
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL reset_txcount: got %h want 0", ReadData); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        tx_ready  = 1'b1;
        MemWrite  = 1'b1;
        DataAdr   = 32'h400;
        WriteData = 32'h0000_0041;
        #1;
        checks++; if (DmemWE !== 1'b0) begin errors++; $display("FAIL single_dmemwe: got %b want 0", DmemWE); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b want 0", tx_valid); end
        @(negedge clk);
        MemWrite = 1'b0;
        DataAdr  = '0;
        #1;
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", tx_valid); end
        checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_data: got %h want 41", tx_data); end
        @(negedge clk);
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got %b want 0", tx_valid); end
        tx_ready = 1'b0;
        set_addr(32'h40C);
        checks++; if (ReadData !== 32'd1) begin errors++; $display("FAIL single_txcount: got %h want 1", ReadData); end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 5; i++) bus_write(32'h400, i);
        set_addr(32'h404);
        checks++; if (ReadData !== 32'h045) begin errors++; $display("FAIL ovf_status: got %h want 045", ReadData); end
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
                errors++; $display("FAIL ovf_drain%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(i));
            end
            @(negedge clk);
        end
        tx_ready = 1'b0;
        set_addr(32'h404);
        checks++; if (ReadData !== 32'h006) begin errors++; $display("FAIL ovf_status_after: got %h want 006", ReadData); end
        set_addr(32'h40C);
        checks++; if (ReadData !== 32'd5) begin errors++; $display("FAIL ovf_txcount: got %h want 5", ReadData); end
        @(negedge clk);
        bus_write(32'h404, 32'h0);
        set_addr(32'h404);
        checks++; if (ReadData !== 32'h002) begin errors++; $display("FAIL ovf_clear: got %h want 002", ReadData); end
        @(negedge clk);
        bus_write(32'h40C, 32'h1234);
        set_addr(32'h40C);
        checks++; if (ReadData !== 32'd0) begin errors++; $display("FAIL txcount_clear: got %h want 0", ReadData); end
        @(negedge clk);
    endtask

    task automatic test_full_push_pop;
        logic [7:0] exp_b [4];
        exp_b = '{8'h12, 8'h13, 8'h14, 8'h99};
        for (int i = 0; i < 4; i++) bus_write(32'h400, 32'h11 + i);
        set_addr(32'h404);
        checks++; if (ReadData !== 32'h041) begin errors++; $display("FAIL full_status: got %h want 041", ReadData); end
        @(negedge clk);
        tx_ready = 1'b1;
        bus_write(32'h400, 32'h99);
        tx_ready = 1'b0;
        set_addr(32'h404);
        checks++; if (ReadData !== 32'h041) begin errors++; $display("FAIL fullpp_status: got %h want 041", ReadData); end
        checks++; if (tx_data !== 8'h12) begin errors++; $display("FAIL fullpp_head: got %h want 12", tx_data); end
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
                errors++; $display("FAIL fullpp_drain%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp_b[i]);
            end
            @(negedge clk);
        end
        tx_ready = 1'b0;
        set_addr(32'h40C);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL fullpp_empty: got %b want 0", tx_valid); end
        checks++; if (ReadData !== 32'd5) begin errors++; $display("FAIL fullpp_txcount: got %h want 5", ReadData); end
        @(negedge clk);
    endtask

    task automatic test_count_one;
        bus_write(32'h400, 32'h21);
        tx_ready = 1'b1;
        bus_write(32'h400, 32'h22);
        tx_ready = 1'b0;
        set_addr(32'h404);
        checks++; if (ReadData !== 32'h010) begin errors++; $display("FAIL cnt1_status: got %h want 010", ReadData); end
        checks++; if (tx_data !== 8'h22) begin errors++; $display("FAIL cnt1_head: got %h want 22", tx_data); end
        @(negedge clk);
        // Clearing TXCOUNT on the same edge as a pop must leave it at 0.
        tx_ready = 1'b1;
        bus_write(32'h40C, 32'h0);
        tx_ready = 1'b0;
        set_addr(32'h40C);
        checks++; if (ReadData !== 32'd0) begin errors++; $display("FAIL clr_with_pop: got %h want 0", ReadData); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL clr_pop_done: got %b want 0", tx_valid); end
        @(negedge clk);
    endtask

    task automatic test_cycle;
        logic [31:0] exp0, exp1, exp2;
`ifdef MMIO_CYCLE_COUNTER_EN
        exp0 = 32'hFFFF_FFFE; exp1 = 32'hFFFF_FFFF; exp2 = 32'h0000_0000;
`else
        exp0 = 32'h0; exp1 = 32'h0; exp2 = 32'h0;
`endif
        MemWrite  = 1'b1;
        DataAdr   = 32'h408;
        WriteData = 32'hFFFF_FFFE;
        #1;
        checks++; if (DmemWE !== 1'b0) begin errors++; $display("FAIL cycle_dmemwe: got %b want 0", DmemWE); end
        @(negedge clk);
        MemWrite = 1'b0;
        #1;
        checks++; if (ReadData !== exp0) begin errors++; $display("FAIL cycle_load: got %h want %h", ReadData, exp0); end
        @(negedge clk);
        #1;
        checks++; if (ReadData !== exp1) begin errors++; $display("FAIL cycle_inc: got %h want %h", ReadData, exp1); end
        @(negedge clk);
        #1;
        checks++; if (ReadData !== exp2) begin errors++; $display("FAIL cycle_wrap: got %h want %h", ReadData, exp2); end
        DataAdr = '0;
        @(negedge clk);
    endtask

    task automatic test_dmem;
        MemReadData = 32'hDEAD_BEEF;
        MemWrite    = 1'b1;
        WriteData   = 32'd25;
        set_addr(32'd100);
        checks++; if (DmemWE !== 1'b1) begin errors++; $display("FAIL dmem_we: got %b want 1", DmemWE); end
        checks++; if (ReadData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dmem_rd: got %h want deadbeef", ReadData); end
        set_addr(32'h410);
        checks++; if (DmemWE !== 1'b1) begin errors++; $display("FAIL dmem_above: got %b want 1", DmemWE); end
        set_addr(32'h3FC);
        checks++; if (DmemWE !== 1'b1 || ReadData !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL dmem_below: got we=%b rd=%h want we=1 rd=deadbeef", DmemWE, ReadData);
        end
        MemWrite = 1'b0;
        set_addr(32'h404);
        checks++; if (ReadData !== 32'h002) begin errors++; $display("FAIL load_status: got %h want 002", ReadData); end
        set_addr(32'h407);
        checks++; if (ReadData !== 32'h002) begin errors++; $display("FAIL load_status_lowbits: got %h want 002", ReadData); end
        set_addr(32'h400);
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL load_txdata: got %h want 0", ReadData); end
        MemReadData = 32'h1234_5678;
        DataAdr     = '0;
        WriteData   = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) bus_write(32'h400, 32'h31 + i);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h31) begin
            errors++; $display("FAIL mid_pre: got v=%b d=%h want v=1 d=31", tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            errors++; $display("FAIL mid_async: got v=%b d=%h want v=0 d=00", tx_valid, tx_data);
        end
        tx_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        set_addr(32'h404);
        checks++; if (ReadData !== 32'h002) begin errors++; $display("FAIL mid_status: got %h want 002", ReadData); end
        set_addr(32'h40C);
        checks++; if (ReadData !== 32'd0) begin errors++; $display("FAIL mid_txcount: got %h want 0", ReadData); end
        @(negedge clk);
        bus_write(32'h400, 32'h55);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h55) begin
            errors++; $display("FAIL mid_resume: got v=%b d=%h want v=1 d=55", tx_valid, tx_data);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset;
        test_single;
        test_overflow;
        test_full_push_pop;
        test_count_one;
        test_cycle;
        test_dmem;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
